// File: rtl/encrypt_config.sv
// rtl/encrypt_config.sv - shared encrypt/decrypt constants, bit permutation and sideband bundle
`ifndef PERM_0
`define PERM_0 3
`define PERM_1 6
`define PERM_2 0
`define PERM_3 5
`define PERM_4 1
`define PERM_5 7
`define PERM_6 2
`define PERM_7 4
`endif

package encrypt_config;

  localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;
  localparam int         ALPHA_LEN        = 26;

  // Sidebands that ride alongside each byte to the next decrypt stage
  typedef struct packed {
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] k3;
    logic [2:0] rot_freq;
    logic       mode;
  } sideband_t;

  // Inverse of scramble: bit i of the scrambled byte returns to position PERM_i
  function automatic logic [7:0] unscramble(input logic [7:0] b);
    logic [7:0] u;
    u = '0;
    u[`PERM_0] = b[0];
    u[`PERM_1] = b[1];
    u[`PERM_2] = b[2];
    u[`PERM_3] = b[3];
    u[`PERM_4] = b[4];
    u[`PERM_5] = b[5];
    u[`PERM_6] = b[6];
    u[`PERM_7] = b[7];
    return u;
  endfunction

  // Encrypt-direction permutation: scrambled bit i is taken from plaintext bit PERM_i
  function automatic logic [7:0] scramble(input logic [7:0] b);
    logic [7:0] s;
    s = '0;
    s[0] = b[`PERM_0];
    s[1] = b[`PERM_1];
    s[2] = b[`PERM_2];
    s[3] = b[`PERM_3];
    s[4] = b[`PERM_4];
    s[5] = b[`PERM_5];
    s[6] = b[`PERM_6];
    s[7] = b[`PERM_7];
    return s;
  endfunction

endpackage

// File: rtl/decrypt_unshift_alpha.sv
// rtl/decrypt_unshift_alpha.sv - combinational mod-26 inverse Caesar shift on one byte
module decrypt_unshift_alpha
  import encrypt_config::*;
#(
  parameter int SHIFT_W = 4
) (
  input  logic [7:0]         din,
  input  logic               is_upper,
  input  logic               is_lower,
  input  logic               shift_en,
  input  logic [SHIFT_W-1:0] shift_amt,
  output logic [7:0]         dout
);

  logic [7:0]        base;
  logic [7:0]        offs;
  logic signed [5:0] idx;
  logic signed [5:0] r;

  // idx is 0..25 and shift_amt 0..15, so the difference fits 6-bit signed and one +26 lands it in range
  always_comb begin
    base = is_upper ? ASCII_UPPER_BASE : ASCII_LOWER_BASE;
    offs = din - base;
    idx  = $signed(offs[5:0]);
    r    = idx - $signed(6'(shift_amt));
    if (r < 0) begin
      r = r + 6'sd26;
    end
    if (shift_en && (is_upper || is_lower)) begin
      dout = base + {2'b00, r[5:0]};
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/decrypt_pipe_unscramble_unshift.sv
// rtl/decrypt_pipe_unscramble_unshift.sv - 2-stage unscramble + inverse shift pipe; DECRYPT_STATS_EN adds alpha_cnt
module decrypt_pipe_unscramble_unshift
  import encrypt_config::*;
#(
  parameter int SHIFT_W = 4
`ifdef DECRYPT_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         din,
  input  logic [7:0]         k1,
  input  logic [7:0]         k2,
  input  logic [7:0]         k3,
  input  logic [2:0]         rot_freq,
  input  logic               shift_en,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         data_out,
  output logic [7:0]         k1_out,
  output logic [7:0]         k2_out,
  output logic [7:0]         k3_out,
  output logic [2:0]         rot_freq_out,
  output logic               mode_out
`ifdef DECRYPT_STATS_EN
  ,
  output logic [CNT_W-1:0]   alpha_cnt
`endif
);

  logic               s1_valid;
  logic               s2_valid;
  logic               adv2;
  logic               in_fire;
  logic [7:0]         u;
  logic               u_upper;
  logic               u_lower;
  logic [7:0]         s1_data;
  logic               s1_upper;
  logic               s1_lower;
  logic               s1_shift_en;
  logic [SHIFT_W-1:0] s1_shift_amt;
  sideband_t          s1_sb;
  sideband_t          s2_sb;
  logic [7:0]         unshift_out;

  assign adv2     = !s2_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign in_fire  = in_valid && in_ready;

  // Bypass bytes skip the permutation so they reach data_out untouched
  assign u       = mode ? din : unscramble(din);
  assign u_upper = (u >= ASCII_UPPER_BASE) && (u <= ASCII_UPPER_BASE + 8'(ALPHA_LEN - 1));
  assign u_lower = (u >= ASCII_LOWER_BASE) && (u <= ASCII_LOWER_BASE + 8'(ALPHA_LEN - 1));

  // Stage 1: capture the unscrambled byte, its class and all controls on input transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_upper     <= 1'b0;
      s1_lower     <= 1'b0;
      s1_shift_en  <= 1'b0;
      s1_shift_amt <= '0;
      s1_sb        <= '0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !adv2);
      if (in_fire) begin
        s1_data      <= u;
        s1_upper     <= u_upper;
        s1_lower     <= u_lower;
        s1_shift_en  <= shift_en;
        s1_shift_amt <= shift_amt;
        s1_sb        <= '{k1: k1, k2: k2, k3: k3, rot_freq: rot_freq, mode: mode};
      end
    end
  end

  // Bypass mode suppresses the shift, so only decrypt-mode alpha bytes get modified
  decrypt_unshift_alpha #(
    .SHIFT_W (SHIFT_W)
  ) u_unshift (
    .din       (s1_data),
    .is_upper  (s1_upper),
    .is_lower  (s1_lower),
    .shift_en  (s1_shift_en && !s1_sb.mode),
    .shift_amt (s1_shift_amt),
    .dout      (unshift_out)
  );

  // Stage 2: load the shifted byte and forwarded sidebands whenever the output slot frees up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      data_out <= '0;
      s2_sb    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= unshift_out;
        s2_sb    <= s1_sb;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign k1_out       = s2_sb.k1;
  assign k2_out       = s2_sb.k2;
  assign k3_out       = s2_sb.k3;
  assign rot_freq_out = s2_sb.rot_freq;
  assign mode_out     = s2_sb.mode;

`ifdef DECRYPT_STATS_EN
  logic s2_applied;

  // Track alongside stage 2 whether the held byte was actually shifted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_applied <= 1'b0;
    end else if (adv2 && s1_valid) begin
      s2_applied <= s1_shift_en && !s1_sb.mode && (s1_upper || s1_lower);
    end
  end

  // Saturating count of output transfers carrying a shifted letter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alpha_cnt <= '0;
    end else if (out_valid && out_ready && s2_applied && (alpha_cnt != {CNT_W{1'b1}})) begin
      alpha_cnt <= alpha_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decrypt_pipe_unscramble_unshift.sv
// tb/tb_decrypt_pipe_unscramble_unshift.sv - directed + random bench with reference model for the decrypt pipe
module tb_decrypt_pipe_unscramble_unshift;
  import encrypt_config::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       shift_en;
  logic [3:0] shift_amt;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic [7:0] k1_out, k2_out, k3_out;
  logic [2:0] rot_freq_out;
  logic       mode_out;
`ifdef DECRYPT_STATS_EN
  logic [15:0] alpha_cnt;
  int          cnt_exp;
`endif

  decrypt_pipe_unscramble_unshift dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .din          (din),
    .k1           (k1),
    .k2           (k2),
    .k3           (k3),
    .rot_freq     (rot_freq),
    .shift_en     (shift_en),
    .shift_amt    (shift_amt),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .k1_out       (k1_out),
    .k2_out       (k2_out),
    .k3_out       (k3_out),
    .rot_freq_out (rot_freq_out),
    .mode_out     (mode_out)
`ifdef DECRYPT_STATS_EN
    ,
    .alpha_cnt    (alpha_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] k3;
    logic [2:0] rf;
    logic       md;
    logic       app;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   bp_rand = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plaintext-level model: Caesar shift undone with ordinary modular arithmetic
  function automatic logic [7:0] ref_byte(input logic [7:0] p, input logic en, input int amt,
                                          input logic md, output logic app);
    int base;
    int r;
    app = 1'b0;
    if (md) return p;
    if (p >= 8'd65 && p <= 8'd90) base = 65;
    else if (p >= 8'd97 && p <= 8'd122) base = 97;
    else base = -1;
    if (!en || base < 0) return p;
    app = 1'b1;
    r = ((int'(p) - base - amt) % 26 + 26) % 26;
    return 8'(base + r);
  endfunction

  // Scoreboard: every output transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(data_out), 64'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_byte_sidebands",
            64'({data_out, k1_out, k2_out, k3_out, rot_freq_out, mode_out}),
            64'({e.d, e.k1, e.k2, e.k3, e.rf, e.md}));
`ifdef DECRYPT_STATS_EN
        if (e.app && cnt_exp < 65535) cnt_exp++;
`endif
      end
    end
  end

  task automatic send(input logic [7:0] plain, input logic en, input logic [3:0] amt, input logic md);
    exp_t e;
    logic app;
    int   waited;
    din       = md ? plain : scramble(plain);
    k1        = 8'($urandom);
    k2        = 8'($urandom);
    k3        = 8'($urandom);
    rot_freq  = 3'($urandom);
    shift_en  = en;
    shift_amt = amt;
    mode      = md;
    in_valid  = 1'b1;
    e.d   = ref_byte(plain, en, int'(amt), md, app);
    e.k1  = k1;
    e.k2  = k2;
    e.k3  = k3;
    e.rf  = rot_freq;
    e.md  = md;
    e.app = app;
    waited = 0;
    forever begin
      if (bp_rand) out_ready = 1'($urandom);
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        chk("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (bp_rand) out_ready = 1'($urandom);
  endtask

  task automatic drain();
    int waited;
    out_ready = 1'b1;
    waited = 0;
    while ((q.size() != 0 || out_valid) && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    din = '0; k1 = '0; k2 = '0; k3 = '0; rot_freq = '0;
    shift_en = 1'b0; shift_amt = '0; mode = 1'b0;
    out_ready = 1'b1;
`ifdef DECRYPT_STATS_EN
    cnt_exp = 0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", 64'({data_out, k1_out, k2_out, k3_out, rot_freq_out, mode_out}), 64'd0);
`ifdef DECRYPT_STATS_EN
    chk("reset_alpha_cnt", 64'(alpha_cnt), 64'd0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // basic decrypt with latency check
    send(8'h44, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    chk("latency_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2_valid", 64'(out_valid), 64'd1);
    chk("basic_D_to_A", 64'(data_out), 64'h41);
    drain();

    // wrap-around, lowercase, non-alpha, bypass, shift disabled, identity shift
    send(8'h42, 1'b1, 4'd3, 1'b0);
    send(8'h61, 1'b1, 4'd15, 1'b0);
    send(8'h35, 1'b1, 4'd7, 1'b0);
    send(8'hA7, 1'b1, 4'd5, 1'b1);
    send(8'h51, 1'b0, 4'd9, 1'b0);
    send(8'h6B, 1'b1, 4'd0, 1'b0);
    send(8'h41, 1'b1, 4'd1, 1'b0);
    drain();

    // backpressure: two accepts fill the pipe, then in_ready must stay low
    out_ready = 1'b0;
    send(8'h45, 1'b1, 4'd4, 1'b0);
    send(8'h46, 1'b1, 4'd4, 1'b0);
    din = 8'h5A;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_out", 64'({out_valid, data_out}), 64'({1'b1, 8'h41}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h47, 1'b1, 4'd4, 1'b0);
    drain();

    // reset mid-stream with both stages full
    out_ready = 1'b0;
    send(8'h4D, 1'b1, 4'd2, 1'b0);
    send(8'h6E, 1'b1, 4'd2, 1'b0);
    @(negedge clk);
    chk("full_before_reset", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_outputs", 64'({data_out, k1_out, k2_out, k3_out, rot_freq_out, mode_out}), 64'd0);
    q.delete();
`ifdef DECRYPT_STATS_EN
    cnt_exp = 0;
`endif
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'h4D, 1'b1, 4'd5, 1'b0);
    drain();

`ifdef DECRYPT_STATS_EN
    chk("stats_after_reset", 64'(alpha_cnt), 64'(cnt_exp));
    send(8'h43, 1'b1, 4'd1, 1'b0);
    send(8'h78, 1'b1, 4'd2, 1'b0);
    send(8'h39, 1'b1, 4'd3, 1'b0);
    send(8'h52, 1'b1, 4'd4, 1'b0);
    drain();
    chk("stats_three_alpha", 64'(alpha_cnt), 64'd4);
`endif

    // randomized traffic with random downstream stalls
    bp_rand = 1;
    for (int n = 0; n < 80; n++) begin
      logic [7:0] p;
      if ($urandom_range(0, 1) == 0) p = 8'($urandom);
      else if ($urandom_range(0, 1) == 0) p = 8'(8'h41 + $urandom_range(0, 25));
      else p = 8'(8'h61 + $urandom_range(0, 25));
      send(p, 1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    bp_rand = 0;
    drain();
`ifdef DECRYPT_STATS_EN
    chk("stats_random", 64'(alpha_cnt), 64'(cnt_exp));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decrypt_pipe_unscramble_unshift.md
Name: decrypt_pipe_unscramble_unshift

Overview:
Decrypt-direction counterpart of the encrypt shift/scramble pipe stage. It receives scrambled bytes from the XOR-undo stage and applies the inverse bit permutation, then the inverse Caesar shift (mod 26) on alphabetic characters. It is a 2-stage valid/ready pipeline with backpressure. Key and control sidebands travel alongside the data to the next decrypt stage.

Parameters:
SHIFT_W, 4, width of shift_amt
CNT_W, 16, width of alpha_cnt (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream byte valid
in_ready  out  1  stage can accept a byte this cycle
din  in  8  scrambled byte
k1, k2, k3  in  8 each  key sidebands
rot_freq  in  3  rotation-frequency sideband
shift_en  in  1  apply inverse shift
shift_amt  in  SHIFT_W  shift amount (0..15)
mode  in  1  0 = decrypt (process); 1 = bypass
out_valid  out  1  data_out valid
out_ready  in  1  downstream accepts
data_out  out  8  plaintext byte
k1_out, k2_out, k3_out  out  8 each  registered sidebands
rot_freq_out  out  3  registered sideband
mode_out  out  1  registered sideband
alpha_cnt  out  CNT_W  present only with DECRYPT_STATS_EN

Behaviour:
- Reset (rst = 0, asynchronous): every register is cleared. out_valid = 0, data_out = 0, all sideband outputs = 0, s1_valid = 0, s2_valid = 0, alpha_cnt = 0. in_ready = 1 after reset.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - adv2 = !s2_valid || out_ready.
  - in_ready = !s1_valid || adv2 (combinational; no skid buffer).
  - A stage holds its contents while not advancing. in_valid and din may change freely while in_ready = 0.
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Sustained throughput is 1 byte/cycle.
- Stage 1 (captured on input transfer):
  - Unscramble: u[PERM_i] = din[i] for i = 0..7, which is the exact inverse of the encrypt scramble.
  - Classify u: upper = 0x41..0x5A, lower = 0x61..0x7A.
  - Register u, upper, lower, shift_en, shift_amt, mode and all sidebands.
  - If mode = 1, register din unchanged (no unscramble).
  - s1_valid is set on input transfer and cleared when stage 1 moves to stage 2 with no new input.
- Stage 2 (loaded when adv2 && s1_valid):
  - If mode = 0, shift_en = 1 and the byte is alphabetic:
    - idx = u − base, where base = 0x41 or 0x61.
    - r = idx − shift_amt; if r < 0 then r = r + 26. Use 6-bit signed arithmetic; the result is always in 0..25.
    - data_out = base + r.
  - Otherwise data_out = u. This covers non-alpha bytes, shift_en = 0, and mode = 1.
  - Sidebands are forwarded unchanged.
- Boundary conditions:
  - Pipe full with out_ready = 0: in_ready = 0 and both stages hold.
  - out_ready returns high with both stages full: stage 2 drains, stage 1 moves to stage 2, and a new input is accepted in the same cycle.
  - shift_amt = 0 produces the identity.
  - Wrap-around: 'A' with shift 1 gives 'Z'.
  - Reset asserted mid-operation discards in-flight bytes with no partial output.

Optional Feature:
DECRYPT_STATS_EN
- Defined:
  - alpha_cnt port present.
  - Counts output transfers in which the inverse shift was actually applied.
  - Saturates at all-ones.
  - Cleared by reset.
- Undefined: port and counter are absent; everything else is identical.

Decomposition:
- Shared package encrypt_config gains:
  - ASCII_UPPER_BASE = 8'h41, ASCII_LOWER_BASE = 8'h61, ALPHA_LEN = 26.
  - Function unscramble(byte) built from the existing PERM_0..PERM_7 macros.
  - Function scramble(byte) for bench use.
  - A packed struct for the sideband bundle {k1, k2, k3, rot_freq, mode}.
- One natural sub-module: decrypt_unshift_alpha, the combinational mod-26 inverse shift (byte, shift_amt, shift_en → byte). It is shared with a future decrypt model check.

Test Plan:
- Basic decrypt: din = scramble(0x44 'D'), shift_en = 1, shift_amt = 3, mode = 0, out_ready = 1 → data_out = 0x41 'A', 2 cycles after transfer.
- Wrap-around and case: din = scramble(0x42 'B'), shift 3 → 0x59 'Y'. din = scramble(0x61 'a'), shift 15 → 0x6C 'l'.
- Non-alpha and bypass: din = scramble(0x35 '5'), shift 7 → 0x35. mode = 1, din = 0xA7 → data_out = 0xA7, mode_out = 1. shift_en = 0 with din = scramble('Q') → 'Q'.
- Backpressure: stream 'E','F','G' (shift 4) with out_ready = 0 for 5 cycles → in_ready drops after 2 accepts with no loss or duplication. Releasing out_ready yields 'A','B','C' in order, sidebands aligned.
- Reset mid-stream: assert rst with both stages valid → out_valid = 0 and all outputs = 0 immediately; first post-reset byte decodes correctly.
- With DECRYPT_STATS_EN: 3 alpha bytes plus 1 digit, all with shift_en = 1 → alpha_cnt = 3. Preloaded saturation stays at 0xFFFF.
